// File: rtl/bram_sdp_rd_arbiter.sv
// bram_sdp_rd_arbiter
// Shares the read port of a single-clock simple-dual-port BRAM between NUM_REQ
// read clients. The write port serves one writer. Read grants are round-robin.
// Each response comes back RD_LATENCY cycles after its grant, marked by a one-hot
// client strobe.
//
// Optional feature macro: BRAM_ARB_COLLISION_BYPASS_EN
//   undefined: a read that collides with a same-cycle write to the same address
//              is deferred. After STALL_MAX deferrals the writer is throttled for
//              one cycle.
//   defined:   a colliding read is granted at once, and the write data is
//              forwarded to the response.
//
// Ports
//   clka, rstb          clock; synchronous active-high reset
//   wr_valid/wr_ready   writer handshake; wr_addr/wr_data give the write target
//   rd_req_valid        per-client read request
//   rd_req_ready        one-hot grant
//   rd_req_addr         packed client addresses, client i at [i*ADDR_W +: ADDR_W]
//   rd_rsp_valid        one-hot response strobe
//   rd_rsp_data         shared response data
//   ram_*               BRAM wrapper pins (addra/dina/wea, addrb/enb/regceb/rstb, doutb)
module bram_sdp_rd_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned RAM_WIDTH  = 64,
    parameter int unsigned RAM_DEPTH  = 512,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned STALL_MAX  = 4,
    localparam int unsigned ADDR_W    = $clog2(RAM_DEPTH)
) (
    input  logic                      clka,
    input  logic                      rstb,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [RAM_WIDTH-1:0]      wr_data,
    input  logic [NUM_REQ-1:0]        rd_req_valid,
    output logic [NUM_REQ-1:0]        rd_req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] rd_req_addr,
    output logic [NUM_REQ-1:0]        rd_rsp_valid,
    output logic [RAM_WIDTH-1:0]      rd_rsp_data,
    output logic [ADDR_W-1:0]         ram_addra,
    output logic [RAM_WIDTH-1:0]      ram_dina,
    output logic                      ram_wea,
    output logic [ADDR_W-1:0]         ram_addrb,
    output logic                      ram_enb,
    output logic                      ram_regceb,
    output logic                      ram_rstb,
    input  logic [RAM_WIDTH-1:0]      ram_doutb
);

    localparam int unsigned CW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [ADDR_W-1:0] req_addr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr
        assign req_addr[g] = rd_req_addr[g*ADDR_W +: ADDR_W];
    end

    logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
    logic              cand_found;
    logic [CW-1:0]     cand_idx;
    logic [ADDR_W-1:0] cand_addr;
    logic              wr_fire;
    logic              addr_match;
    logic              collision;
    logic              grant;

    // Round-robin search starting at rr_ptr.
    always_comb begin
        logic [CW-1:0] idx;
        idx        = '0;
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = CW'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!cand_found && rd_req_valid[idx]) begin
                cand_found = 1'b1;
                cand_idx   = idx;
            end
        end
    end

    assign cand_addr  = req_addr[cand_idx];
    assign wr_fire    = wr_valid & wr_ready;
    assign addr_match = cand_found & wr_fire & (cand_addr == wr_addr);

`ifdef BRAM_ARB_COLLISION_BYPASS_EN
    // Colliding reads are served from the forwarded write data, so they are never deferred.
    assign wr_ready  = ~rstb;
    assign collision = 1'b0;
`else
    localparam int unsigned SW = $clog2(STALL_MAX + 1);

    logic [SW-1:0] stall_cnt_q, stall_cnt_d;
    logic          throttle;

    // One write bubble after STALL_MAX deferrals lets the starved read through.
    assign throttle  = (stall_cnt_q == SW'(STALL_MAX));
    assign wr_ready  = ~rstb & ~throttle;
    assign collision = addr_match;

    always_comb begin
        stall_cnt_d = '0;
        if (collision) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

    assign grant = cand_found & ~collision & ~rstb;

    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        rd_req_ready = '0;
        if (grant) begin
            rd_req_ready[cand_idx] = 1'b1;
            rr_ptr_d = (cand_idx == CW'(NUM_REQ - 1)) ? '0 : cand_idx + 1'b1;
        end
    end

    assign ram_addra  = wr_addr;
    assign ram_dina   = wr_data;
    assign ram_wea    = wr_fire;
    assign ram_addrb  = cand_addr;
    assign ram_enb    = grant;
    assign ram_regceb = (RD_LATENCY == 2);
    assign ram_rstb   = rstb;

    // Response tag pipeline: stage RD_LATENCY-1 lines up with valid doutb.
    logic [RD_LATENCY-1:0] tag_v_q, tag_v_d;
    logic [CW-1:0]         tag_id_q [RD_LATENCY];
    logic [CW-1:0]         tag_id_d [RD_LATENCY];
    logic [RAM_WIDTH-1:0]  rsp_data_q, rsp_data_d;
    logic [RAM_WIDTH-1:0]  rsp_src;
    logic                  rsp_fire;

    always_comb begin
        tag_v_d[0]  = grant;
        tag_id_d[0] = cand_idx;
        for (int s = 1; s < RD_LATENCY; s++) begin
            tag_v_d[s]  = tag_v_q[s-1];
            tag_id_d[s] = tag_id_q[s-1];
        end
    end

`ifdef BRAM_ARB_COLLISION_BYPASS_EN
    logic [RD_LATENCY-1:0] tag_b_q, tag_b_d;
    logic [RAM_WIDTH-1:0]  tag_bd_q [RD_LATENCY];
    logic [RAM_WIDTH-1:0]  tag_bd_d [RD_LATENCY];

    always_comb begin
        tag_b_d[0]  = grant & addr_match;
        tag_bd_d[0] = wr_data;
        for (int s = 1; s < RD_LATENCY; s++) begin
            tag_b_d[s]  = tag_b_q[s-1];
            tag_bd_d[s] = tag_bd_q[s-1];
        end
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            tag_b_q <= '0;
        end else begin
            tag_b_q <= tag_b_d;
        end
    end

    // Pure data path, no reset needed.
    always_ff @(posedge clka) begin
        tag_bd_q <= tag_bd_d;
    end

    assign rsp_src = tag_b_q[RD_LATENCY-1] ? tag_bd_q[RD_LATENCY-1] : ram_doutb;
`else
    assign rsp_src = ram_doutb;
`endif

    // Gated by rstb so that no response escapes in the cycle reset asserts.
    assign rsp_fire = tag_v_q[RD_LATENCY-1] & ~rstb;

    always_comb begin
        rd_rsp_valid = '0;
        rd_rsp_data  = rsp_data_q;
        if (rsp_fire) begin
            rd_rsp_valid[tag_id_q[RD_LATENCY-1]] = 1'b1;
            rd_rsp_data = rsp_src;
        end
        rsp_data_d = rd_rsp_data;
    end

    always_ff @(posedge clka) begin
        if (rstb) begin
            rr_ptr_q   <= '0;
            tag_v_q    <= '0;
            tag_id_q   <= '{default: '0};
            rsp_data_q <= '0;
        end else begin
            rr_ptr_q   <= rr_ptr_d;
            tag_v_q    <= tag_v_d;
            tag_id_q   <= tag_id_d;
            rsp_data_q <= rsp_data_d;
        end
    end

endmodule

// File: tb/tb_bram_sdp_rd_arbiter.sv
module tb_bram_sdp_rd_arbiter;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 64;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;
    localparam int unsigned LAT   = 2;
    localparam int unsigned SMAX  = 4;
`ifdef BRAM_ARB_COLLISION_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic            clka = 1'b0;
    logic            rstb;
    logic            wr_valid;
    logic            wr_ready;
    logic [AW-1:0]   wr_addr;
    logic [W-1:0]    wr_data;
    logic [N-1:0]    rd_req_valid;
    logic [N-1:0]    rd_req_ready;
    logic [N*AW-1:0] rd_req_addr;
    logic [N-1:0]    rd_rsp_valid;
    logic [W-1:0]    rd_rsp_data;
    logic [AW-1:0]   ram_addra;
    logic [W-1:0]    ram_dina;
    logic            ram_wea;
    logic [AW-1:0]   ram_addrb;
    logic            ram_enb;
    logic            ram_regceb;
    logic            ram_rstb;
    logic [W-1:0]    ram_doutb;

    always #5 clka = ~clka;

    bram_sdp_rd_arbiter #(
        .NUM_REQ    (N),
        .RAM_WIDTH  (W),
        .RAM_DEPTH  (DEPTH),
        .RD_LATENCY (LAT),
        .STALL_MAX  (SMAX)
    ) dut (
        .clka         (clka),
        .rstb         (rstb),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .rd_req_valid (rd_req_valid),
        .rd_req_ready (rd_req_ready),
        .rd_req_addr  (rd_req_addr),
        .rd_rsp_valid (rd_rsp_valid),
        .rd_rsp_data  (rd_rsp_data),
        .ram_addra    (ram_addra),
        .ram_dina     (ram_dina),
        .ram_wea      (ram_wea),
        .ram_addrb    (ram_addrb),
        .ram_enb      (ram_enb),
        .ram_regceb   (ram_regceb),
        .ram_rstb     (ram_rstb),
        .ram_doutb    (ram_doutb)
    );

    // SDP BRAM stand-in: read-first array, optional output register.
    logic [W-1:0] bram [DEPTH];
    logic [W-1:0] bram_s1;
    logic [W-1:0] bram_dout_q;

    always @(posedge clka) begin
        if (ram_wea) bram[ram_addra] <= ram_dina;
        if (ram_enb) bram_s1 <= bram[ram_addrb];
        if (ram_rstb) bram_dout_q <= '0;
        else if (ram_regceb) bram_dout_q <= bram_s1;
    end

    assign ram_doutb = (LAT == 2) ? bram_dout_q : bram_s1;

    // Reference model state
    typedef struct {
        int unsigned  due;
        int           id;
        logic [W-1:0] data;
    } rsp_t;

    int           checks = 0;
    int           failures = 0;
    int unsigned  cyc = 0;
    int           m_ptr = 0;
    int           m_stall = 0;
    logic [W-1:0] m_last = '0;
    logic [W-1:0] ref_mem [DEPTH];
    rsp_t         rsp_q [$];
    logic [N-1:0] clr_mask = '0;
    int           wr_block_obs = 0;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_addr(input int c, input logic [AW-1:0] a);
        rd_req_addr[c*AW +: AW] = a;
    endtask

    // Called mid-cycle: compares DUT outputs with the rules, then advances the model.
    task automatic evaluate();
        int           cand;
        bit           wr_rdy_exp, acc, hit, coll, grant;
        logic [AW-1:0] ca;
        logic [N-1:0] exp_ready, exp_valid;
        logic [W-1:0] exp_data;
        rsp_t         r;
        clr_mask = '0;
        if (rstb) begin
            chk("rst_wr_ready", W'(wr_ready), '0);
            chk("rst_rd_req_ready", W'(rd_req_ready), '0);
            chk("rst_ram_wea", W'(ram_wea), '0);
            chk("rst_ram_enb", W'(ram_enb), '0);
            chk("rst_rd_rsp_valid", W'(rd_rsp_valid), '0);
            m_ptr = 0;
            m_stall = 0;
            m_last = '0;
            rsp_q.delete();
            return;
        end
        wr_rdy_exp = BYP || (m_stall != SMAX);
        if (!wr_ready) wr_block_obs++;
        chk("wr_ready", W'(wr_ready), W'(wr_rdy_exp));
        acc = wr_valid && wr_rdy_exp;
        cand = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
            if (cand < 0 && rd_req_valid[j]) cand = j;
        end
        hit = 1'b0;
        ca = '0;
        if (cand >= 0) begin
            ca = rd_req_addr[cand*AW +: AW];
            hit = acc && (ca == wr_addr);
        end
        coll = hit && !BYP;
        grant = (cand >= 0) && !coll;
        exp_ready = '0;
        if (grant) exp_ready[cand] = 1'b1;
        chk("rd_req_ready", W'(rd_req_ready), W'(exp_ready));
        chk("ram_enb", W'(ram_enb), W'(grant));
        if (grant) begin
            chk("ram_addrb", W'(ram_addrb), W'(ca));
            r.due = cyc + LAT;
            r.id = cand;
            r.data = hit ? wr_data : ref_mem[ca];
            rsp_q.push_back(r);
            clr_mask[cand] = 1'b1;
        end
        chk("ram_wea", W'(ram_wea), W'(acc));
        if (acc) begin
            chk("ram_addra", W'(ram_addra), W'(wr_addr));
            chk("ram_dina", ram_dina, wr_data);
        end
        exp_valid = '0;
        exp_data = m_last;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            exp_valid[rsp_q[0].id] = 1'b1;
            exp_data = rsp_q[0].data;
            m_last = exp_data;
            void'(rsp_q.pop_front());
        end
        chk("rd_rsp_valid", W'(rd_rsp_valid), W'(exp_valid));
        chk("rd_rsp_data", rd_rsp_data, exp_data);
        if (acc) ref_mem[wr_addr] = wr_data;
        if (grant) begin
            m_ptr = (cand + 1) % N;
            m_stall = 0;
        end else if (coll) begin
            m_stall++;
        end else begin
            m_stall = 0;
        end
    endtask

    // One clock: check at the falling edge, retire granted requests after the rising edge.
    task automatic step();
        @(negedge clka);
        evaluate();
        @(posedge clka);
        #1;
        rd_req_valid = rd_req_valid & ~clr_mask;
        cyc++;
    endtask

    initial begin
        rstb = 1'b1;
        wr_valid = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        rd_req_valid = '0;
        rd_req_addr = '0;
        repeat (3) step();
        rstb = 1'b0;
        chk("ram_regceb", W'(ram_regceb), W'(LAT == 2));

        // Preload the low 64 entries through the write port.
        for (int a = 0; a < 64; a++) begin
            wr_valid = 1'b1;
            wr_addr = AW'(a);
            wr_data = {$urandom, $urandom};
            step();
        end
        wr_addr = 9'h010;
        wr_data = 64'hAAAA;
        step();
        wr_valid = 1'b0;

        // Single read by client 2.
        set_addr(2, 9'h010);
        rd_req_valid = 4'b0100;
        step();
        repeat (3) step();

        // Fresh reset, then all clients requesting every cycle.
        rstb = 1'b1;
        step();
        rstb = 1'b0;
        for (int c = 0; c < N; c++) set_addr(c, AW'($urandom_range(0, 63)));
        for (int i = 0; i < 5; i++) begin
            rd_req_valid = 4'hF;
            step();
        end
        rd_req_valid = '0;
        repeat (3) step();

        // Same-cycle write/read collision.
        wr_valid = 1'b1;
        wr_addr = 9'h020;
        wr_data = 64'h55;
        set_addr(1, 9'h020);
        rd_req_valid = 4'b0010;
        step();
        wr_valid = 1'b0;
        repeat (4) step();

        // Streaming writer against a held read of the same address.
        set_addr(0, 9'h030);
        rd_req_valid = 4'b0001;
        wr_valid = 1'b1;
        wr_addr = 9'h030;
        wr_block_obs = 0;
        for (int i = 0; i < 8; i++) begin
            wr_data = {$urandom, $urandom};
            step();
        end
        chk("throttle_cycles", W'(wr_block_obs), BYP ? '0 : W'(1));
        wr_valid = 1'b0;
        repeat (3) step();

        // Reset one cycle after a grant.
        set_addr(3, 9'h005);
        rd_req_valid = 4'b1000;
        step();
        rstb = 1'b1;
        repeat (2) step();
        rstb = 1'b0;
        set_addr(1, 9'h011);
        set_addr(3, 9'h012);
        rd_req_valid = 4'b1010;
        step();
        rd_req_valid = '0;
        repeat (4) step();

        // Random traffic on a small address window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_addr = AW'($urandom_range(0, 7));
            wr_data = {$urandom, $urandom};
            for (int c = 0; c < N; c++) begin
                if (!rd_req_valid[c] && $urandom_range(0, 2) == 0) begin
                    rd_req_valid[c] = 1'b1;
                    set_addr(c, AW'($urandom_range(0, 7)));
                end
            end
            if (i == 200) rstb = 1'b1;
            if (i == 202) rstb = 1'b0;
            step();
        end
        wr_valid = 1'b0;
        rd_req_valid = '0;
        repeat (40) step();
        chk("rsp_queue_drained", W'(rsp_q.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
